// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arbiter_pkg;

  // FSM encoding, fixed so that state dumps read the same everywhere.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Requester identifiers.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Access counter width; LATENCY is limited to 1..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the requester handshakes and the RAM-side bus of ram_arbiter.
// slave: the arbiter's view. master: the surrounding system (requesters and RAM).
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  // Port 0: Memory stage
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_done;
  logic                  cpu_stall;

  // Port 1: debug / loader
  logic                  dbg_req;
  logic                  dbg_we;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_wdata;
  logic [DATA_WIDTH-1:0] dbg_rdata;
  logic                  dbg_done;

  // RAM side
  logic                  ram_enable;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_done,
    output ram_enable, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_done,
    input  ram_enable, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  busy
  );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-requester round-robin picker.
// With a single requester it is granted; on contention the port that did not
// win the previous contention (i_last) is granted.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant_valid,
  output logic       o_grant_id
);

  // Choose the granted port from the request pair and the previous winner.
  always_comb begin
    o_grant_valid = |i_req;
    o_grant_id    = PORT_CPU;
    if (i_req == 2'b11) begin
      o_grant_id = ~i_last;
    end else if (i_req[1]) begin
      o_grant_id = PORT_DBG;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port RAM between the Memory stage (port 0) and a
// debug/loader port (port 1). One request is latched at a time, the RAM lines
// are held for LATENCY cycles, then the granted port gets a one-cycle done.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic           clock,
  input  logic           reset,
  ram_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_last;
  logic                  r_port;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_dbg_rdata;

  logic                  r_ram_enable;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;

  logic [1:0]            w_req;
  logic                  w_grant_valid;
  logic                  w_grant_id;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_cpu_done;
  logic                  w_dbg_done;

  assign w_req = {bus.dbg_req, bus.cpu_req};

  rr_pick2 u_pick (
    .i_req         (w_req),
    .i_last        (r_last),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> ACCESS on any request, ACCESS -> DONE when the
  // counter expires, DONE always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_valid) w_state_nxt = S_ACCESS;
      S_ACCESS: if (r_cnt == '0)   w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Access attributes for the next RAM cycle: the granted port's inputs while
  // IDLE, the latched copy once the transaction has started.
  always_comb begin
    w_sel_we    = r_we;
    w_sel_addr  = r_addr;
    w_sel_wdata = r_wdata;
    if (r_state == S_IDLE) begin
      if (w_grant_id == PORT_DBG) begin
        w_sel_we    = bus.dbg_we;
        w_sel_addr  = bus.dbg_addr;
        w_sel_wdata = bus.dbg_wdata;
      end else begin
        w_sel_we    = bus.cpu_we;
        w_sel_addr  = bus.cpu_addr;
        w_sel_wdata = bus.cpu_wdata;
      end
    end
  end

  // Transaction latches, access counter, contention history and read data.
  // The round-robin history only moves on contention, so alternating winners
  // are guaranteed when both ports keep colliding.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt       <= '0;
      r_last      <= PORT_DBG;
      r_port      <= PORT_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_port  <= w_grant_id;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= CNT_INIT;
            if (&w_req) r_last <= w_grant_id;
          end
        end
        S_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (!r_we) begin
            if (r_port == PORT_DBG) r_dbg_rdata <= bus.ram_rdata;
            else                    r_cpu_rdata <= bus.ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered RAM strobes: driven exactly for the cycles spent in ACCESS,
  // zero otherwise, with no combinational path from the requests.
  always_ff @(posedge clock) begin
    if (reset || (w_state_nxt != S_ACCESS)) begin
      r_ram_enable <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
    end else begin
      r_ram_enable <= 1'b1;
      r_ram_we     <= w_sel_we;
      r_ram_addr   <= w_sel_addr;
      r_ram_wdata  <= w_sel_wdata;
    end
  end

  assign w_cpu_done = (r_state == S_DONE) && (r_port == PORT_CPU);
  assign w_dbg_done = (r_state == S_DONE) && (r_port == PORT_DBG);

  assign bus.cpu_done   = w_cpu_done;
  assign bus.dbg_done   = w_dbg_done;
  assign bus.cpu_stall  = bus.cpu_req & ~w_cpu_done;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.dbg_rdata  = r_dbg_rdata;
  assign bus.ram_enable = r_ram_enable;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with LATENCY = 2 and a behavioural RAM.
module tb_ram_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous single-port RAM model
  logic [DW-1:0] mem [256];
  always @(posedge clock) begin
    if (bus.ram_enable && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    int            cyc;
    logic          we;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t q_cpu[$];
  exp_t q_dbg[$];
  exp_t m_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation of its port
  always @(negedge clock) begin
    if (bus.cpu_done) begin
      if (q_cpu.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL cpu_done_unexpected: got done at cycle %0d, expected none", cyc);
      end else begin
        m_e = q_cpu.pop_front();
        chk("cpu_done_cycle", 64'(cyc), 64'(m_e.cyc));
        if (!m_e.we) chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(m_e.rdata));
      end
    end
    if (bus.dbg_done) begin
      if (q_dbg.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dbg_done_unexpected: got done at cycle %0d, expected none", cyc);
      end else begin
        m_e = q_dbg.pop_front();
        chk("dbg_done_cycle", 64'(cyc), 64'(m_e.cyc));
        if (!m_e.we) chk("dbg_rdata", 64'(bus.dbg_rdata), 64'(m_e.rdata));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_done(input logic port, input logic we, input logic [DW-1:0] rdata, input int dly);
    exp_t e;
    e.cyc = cyc + dly; e.we = we; e.rdata = rdata;
    if (port) q_dbg.push_back(e);
    else      q_cpu.push_back(e);
  endtask

  task automatic drive(input logic port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port) begin
      bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  // Hold each port's request until its expectations are consumed, then drop it
  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q_cpu.size() == 0) bus.cpu_req = 1'b0;
      if (q_dbg.size() == 0) bus.dbg_req = 1'b0;
      if (q_cpu.size() == 0 && q_dbg.size() == 0) return;
      step();
    end
    n_tests++; n_fail++;
    $display("FAIL drain_timeout: got %0d cpu + %0d dbg pending, expected 0", q_cpu.size(), q_dbg.size());
    q_cpu.delete(); q_dbg.delete();
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
  endtask

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Reset then idle
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("idle_ctrl", 64'({bus.busy, bus.cpu_done, bus.dbg_done, bus.ram_enable, bus.ram_we, bus.cpu_stall}), 64'(0));
      chk("idle_ram_bus", 64'({bus.ram_addr, bus.ram_wdata}), 64'(0));
      chk("idle_rdata", {bus.cpu_rdata, bus.dbg_rdata}, 64'(0));
    end
    step();

    // CPU write 0x03 = DEADBEEF, check RAM lines cycle by cycle
    drive(0, 1, 8'h03, 32'hDEADBEEF);
    expect_done(0, 1, '0, LAT + 1);
    @(negedge clock);
    chk("wr_stall_req", 64'(bus.cpu_stall), 64'(1));
    for (int k = 1; k <= 3; k++) begin
      step();
      @(negedge clock);
      if (k < 3) begin
        chk("wr_ram_ctrl", 64'({bus.ram_enable, bus.ram_we, bus.busy}), 64'(3'b111));
        chk("wr_ram_addr", 64'(bus.ram_addr), 64'(8'h03));
        chk("wr_ram_wdata", 64'(bus.ram_wdata), 64'(32'hDEADBEEF));
        chk("wr_stall_access", 64'(bus.cpu_stall), 64'(1));
      end else begin
        chk("wr_ram_off_in_done", 64'({bus.ram_enable, bus.ram_we}), 64'(0));
        chk("wr_stall_done", 64'(bus.cpu_stall), 64'(0));
      end
    end
    step();
    wait_drain(20);

    // CPU read back; dbg rdata must not move
    drive(0, 0, 8'h03, '0);
    expect_done(0, 0, 32'hDEADBEEF, LAT + 1);
    wait_drain(20);
    chk("dbg_rdata_unchanged", 64'(bus.dbg_rdata), 64'(0));

    // dbg read of the same word
    drive(1, 0, 8'h03, '0);
    expect_done(1, 0, 32'hDEADBEEF, LAT + 1);
    wait_drain(20);
    chk("cpu_rdata_held", 64'(bus.cpu_rdata), 64'(32'hDEADBEEF));

    // First contention: CPU wins, dbg follows one transaction later
    drive(0, 1, 8'h20, 32'h11112222);
    drive(1, 0, 8'h03, '0);
    expect_done(0, 1, '0, LAT + 1);
    expect_done(1, 0, 32'hDEADBEEF, 2 * LAT + 3);
    wait_drain(30);

    // Repeated contention: dbg wins this time
    drive(0, 0, 8'h20, '0);
    drive(1, 1, 8'h21, 32'hCAFEF00D);
    expect_done(1, 1, '0, LAT + 1);
    expect_done(0, 0, 32'h11112222, 2 * LAT + 3);
    wait_drain(30);

    // cpu_req dropped after one cycle of a write: it still completes
    drive(0, 1, 8'h10, 32'h0BADF00D);
    expect_done(0, 1, '0, LAT + 1);
    step();
    bus.cpu_req = 1'b0; bus.cpu_addr = 8'hFF; bus.cpu_wdata = '0;
    wait_drain(20);
    drive(1, 0, 8'h10, '0);
    expect_done(1, 0, 32'h0BADF00D, LAT + 1);
    wait_drain(20);

    // Held request: stall profile and done pulses 4 cycles apart
    drive(0, 0, 8'h21, '0);
    expect_done(0, 0, 32'hCAFEF00D, LAT + 1);
    expect_done(0, 0, 32'hCAFEF00D, 2 * LAT + 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("held_stall", 64'(bus.cpu_stall), 64'(k != 3));
      step();
    end
    wait_drain(20);

    // Reset in the middle of ACCESS: no done, rdata cleared, back to IDLE
    drive(0, 0, 8'h03, '0);
    step();
    @(negedge clock);
    chk("abort_busy_before", 64'(bus.busy), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clock);
    chk("abort_ctrl", 64'({bus.busy, bus.cpu_done, bus.ram_enable, bus.ram_we}), 64'(0));
    chk("abort_rdata", {bus.cpu_rdata, bus.dbg_rdata}, 64'(0));
    repeat (6) step();
    chk("queues_empty", 64'(q_cpu.size() + q_dbg.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and access sequencer that shares the CPU's single-port data RAM between the Memory stage (port 0) and a debug/loader port (port 1). It sits between those requesters and the RAM instance. It latches one request at a time, holds the RAM address, control and write-data lines for a fixed access latency, and returns read data with a single-cycle done pulse. When both ports request, round-robin priority applies.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM word-address width
- DATA_WIDTH, 32, RAM data width
- LATENCY, 2, cycles the RAM needs per access; legal range 1..15

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  Memory-stage request (level)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_rdata  out  DATA_WIDTH  read data, valid from cpu_done onward
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_done (combinational), drives pipeline stall
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_done: same as the cpu_* ports, for port 1
- ram_enable  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states and transitions:
  - IDLE: no transaction in progress.
  - ACCESS: RAM lines held for LATENCY cycles.
  - DONE: one-cycle completion.
  - IDLE → ACCESS when any req is high.
  - ACCESS → DONE when cnt == 0.
  - DONE → IDLE unconditionally.
- Grant at the IDLE edge:
  - Only one req high: that port is granted.
  - Both high: the port not granted last time is granted. The last-grant register resets to port 1, so port 0 wins the first contention.
- On grant, latch into internal registers: port id, we, addr, wdata. Set cnt = LATENCY-1.
- ACCESS:
  - ram_enable = 1.
  - ram_we = latched we.
  - ram_addr and ram_wdata come from the latches, stable for every ACCESS cycle.
  - Each cycle cnt decrements.
  - At cnt == 0, the next edge captures ram_rdata into the granted port's rdata register, only for reads. rdata is unchanged for writes.
- DONE: the granted port's done = 1 for exactly one cycle. The other port's done stays 0.
- Requester rules:
  - Hold req, we, addr and wdata stable until done.
  - req still high in the cycle after done is treated as a new request.
- If req drops mid-transaction, the transaction still completes. The write is committed and done still pulses.
- Outside ACCESS: ram_enable = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
- An unrequested port's rdata holds its last value.

## Timing
- Reset: the synchronous reset forces:
  - state = IDLE, cnt = 0, last-grant = port 1
  - all latches = 0
  - cpu_rdata = dbg_rdata = 0
  - cpu_done = dbg_done = 0
  - busy = 0
  - all ram_* outputs = 0
- Reset asserted mid-ACCESS or mid-DONE aborts the transaction: no done pulse, no rdata update. A write already driven to the RAM is not rolled back.
- Transaction latency, for a req sampled high in IDLE at cycle N:
  - ACCESS occupies cycles N+1 … N+LATENCY.
  - done is high in cycle N+LATENCY+1.
  - rdata is valid from N+LATENCY+1 onward.
- Throughput: one transaction per LATENCY+2 cycles. Back-to-back requests from one port are separated by one IDLE cycle.
- A losing requester waits exactly one full transaction: its grant occurs in the IDLE cycle after the winner's DONE.
- ram_we and ram_enable are registered outputs, with no combinational path from any *_req.

## Structure
- Shared package `ram_arbiter_pkg`:
  - state encoding constants: S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2
  - port ids: PORT_CPU = 0, PORT_DBG = 1
- Natural sub-module: `rr_pick2`, a combinational two-input round-robin picker. Inputs: req[1:0], last. Outputs: grant_valid, grant_id.
- The FSM, counter, latches and output registers stay in `ram_arbiter`.

## Test plan
All scenarios use LATENCY = 2.
- Reset then idle: all outputs 0 and busy = 0 for 5 cycles; a reset pulse mid-ACCESS returns to IDLE with no done.
- CPU write: addr 0x03, data 0xDEADBEEF, req at cycle N.
  - ram_we = 1 and ram_addr = 0x03 during N+1..N+2.
  - cpu_done high at N+3 only.
- CPU read back of 0x03: cpu_rdata = 0xDEADBEEF at N+3; dbg_rdata unchanged.
- Simultaneous req from both ports at cycle N:
  - CPU granted first, cpu_done at N+3.
  - dbg granted at N+4, dbg_done at N+7.
  - Repeating the contention grants dbg first.
- cpu_req dropped after one cycle of a write to 0x10: the write still lands (verified by a dbg read of 0x10) and cpu_done still pulses.
- cpu_stall is high from req until the done cycle and is low in the done cycle; with cpu_req held high continuously, back-to-back done pulses occur 4 cycles apart.
